// File: rtl/fp_normalize_pipe_if.sv
// Handshake/data bundle around the post-add normaliser.
// master = upstream producer plus downstream consumer; slave = the normaliser itself.
interface fp_normalize_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 24
);
  // valid/ready contract, both sides: a beat transfers on the clock edge where
  // valid && ready. While valid is high and ready is low, the sender holds
  // valid and its data stable. Ready may depend combinationally on the
  // downstream ready; valid never depends on ready.
  logic             in_valid;
  logic             in_ready;
  logic [MAN_W:0]   in_mant;
  logic [EXP_W-1:0] in_exp;

  logic             out_valid;
  logic             out_ready;
  logic [MAN_W-1:0] out_mant;
  logic [EXP_W-1:0] out_exp;
  logic             out_sticky;
  logic             out_ovf;
  logic             out_unf;
  logic             out_zero;

  modport master (
    output in_valid, in_mant, in_exp, out_ready,
    input  in_ready, out_valid, out_mant, out_exp,
           out_sticky, out_ovf, out_unf, out_zero
  );

  modport slave (
    input  in_valid, in_mant, in_exp, out_ready,
    output in_ready, out_valid, out_mant, out_exp,
           out_sticky, out_ovf, out_unf, out_zero
  );
endinterface

// File: rtl/fp_normalize_pipe.sv
// Two-stage post-add normaliser: S1 classifies and counts leading zeros,
// S2 shifts the mantissa, adjusts the exponent and raises the exception flags.
module fp_normalize_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 24
) (
  input  logic                clk,
  input  logic                rst,
  fp_normalize_pipe_if.slave  bus
);

  localparam int LZ_W = (MAN_W > 1) ? $clog2(MAN_W) : 1;
  localparam logic [EXP_W-1:0] EXP_MAX     = '1;
  localparam logic [EXP_W:0]   EXP_MAX_EXT = {1'b0, EXP_MAX};
  localparam logic [EXP_W:0]   OVF_LIM     = EXP_MAX_EXT - (EXP_W+1)'(1);

  typedef enum logic [1:0] {
    CLS_NORM    = 2'd0,
    CLS_ZERO    = 2'd1,
    CLS_CARRY   = 2'd2,
    CLS_INF_NAN = 2'd3
  } cls_e;

  // Leading zeros of the fraction field; an all-zero field reports MAN_W-1,
  // which only matters for classes that never use the count.
  function automatic logic [LZ_W-1:0] lead_zeros(input logic [MAN_W-1:0] m);
    logic [LZ_W-1:0] n;
    n = LZ_W'(MAN_W - 1);
    for (int i = 0; i < MAN_W; i++) begin
      if (m[i]) n = LZ_W'(MAN_W - 1 - i);
    end
    return n;
  endfunction

  // Stage 1 registers
  logic             s1_valid;
  logic [MAN_W:0]   s1_mant;
  logic [EXP_W-1:0] s1_exp;
  cls_e             s1_cls;
  logic [LZ_W-1:0]  s1_lz;

  // Stage 2 registers (drive the outputs directly)
  logic             s2_valid;
  logic [MAN_W-1:0] s2_mant;
  logic [EXP_W-1:0] s2_exp;
  logic             s2_sticky;
  logic             s2_ovf;
  logic             s2_unf;
  logic             s2_zero;

  logic s1_load;
  logic s2_load;

  assign s2_load     = !s2_valid || bus.out_ready;
  assign s1_load     = !s1_valid || s2_load;
  assign bus.in_ready = s1_load;

  // S1 classification, priority top-down
  cls_e            cls_c;
  logic [LZ_W-1:0] lz_c;

  always_comb begin
    cls_c = CLS_NORM;
    lz_c  = lead_zeros(bus.in_mant[MAN_W-1:0]);
    if (bus.in_exp == EXP_MAX)
      cls_c = CLS_INF_NAN;
    else if (bus.in_mant[MAN_W])
      cls_c = CLS_CARRY;
    else if (bus.in_mant == '0)
      cls_c = CLS_ZERO;
    else
      cls_c = CLS_NORM;
  end

  // S2 result; exponent arithmetic is one bit wider so nothing wraps
  logic [MAN_W-1:0] nx_mant;
  logic [EXP_W-1:0] nx_exp;
  logic             nx_sticky;
  logic             nx_ovf;
  logic             nx_unf;
  logic             nx_zero;
  logic [EXP_W:0]   exp_ext;
  logic [EXP_W:0]   lz_ext;
  logic [EXP_W:0]   exp_calc;
  logic [EXP_W:0]   shamt;

  always_comb begin
    nx_mant   = '0;
    nx_exp    = '0;
    nx_sticky = 1'b0;
    nx_ovf    = 1'b0;
    nx_unf    = 1'b0;
    nx_zero   = 1'b0;
    exp_ext   = {1'b0, s1_exp};
    lz_ext    = (EXP_W+1)'(s1_lz);
    exp_calc  = '0;
    shamt     = '0;
    case (s1_cls)
      CLS_INF_NAN: begin
        nx_exp  = EXP_MAX;
        nx_mant = s1_mant[MAN_W-1:0];
      end
      CLS_CARRY: begin
        if (exp_ext >= OVF_LIM) begin
          nx_exp = EXP_MAX;
          nx_ovf = 1'b1;
        end else begin
          exp_calc  = exp_ext + (EXP_W+1)'(1);
          nx_exp    = exp_calc[EXP_W-1:0];
          nx_mant   = s1_mant[MAN_W:1];
          nx_sticky = s1_mant[0];
        end
      end
      CLS_ZERO: begin
        nx_zero = 1'b1;
      end
      default: begin
        if (exp_ext > lz_ext) begin
          exp_calc = exp_ext - lz_ext;
          nx_exp   = exp_calc[EXP_W-1:0];
          nx_mant  = s1_mant[MAN_W-1:0] << s1_lz;
        end else begin
          // Subnormal: scale stops at exponent 1, stored exponent is 0
          nx_unf  = 1'b1;
          shamt   = (s1_exp == '0) ? '0 : exp_ext - (EXP_W+1)'(1);
          nx_mant = s1_mant[MAN_W-1:0] << shamt;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_mant   <= '0;
      s1_exp    <= '0;
      s1_cls    <= CLS_NORM;
      s1_lz     <= '0;
      s2_valid  <= 1'b0;
      s2_mant   <= '0;
      s2_exp    <= '0;
      s2_sticky <= 1'b0;
      s2_ovf    <= 1'b0;
      s2_unf    <= 1'b0;
      s2_zero   <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_mant <= bus.in_mant;
          s1_exp  <= bus.in_exp;
          s1_cls  <= cls_c;
          s1_lz   <= lz_c;
        end
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_mant   <= nx_mant;
          s2_exp    <= nx_exp;
          s2_sticky <= nx_sticky;
          s2_ovf    <= nx_ovf;
          s2_unf    <= nx_unf;
          s2_zero   <= nx_zero;
        end
      end
    end
  end

  assign bus.out_valid  = s2_valid;
  assign bus.out_mant   = s2_mant;
  assign bus.out_exp    = s2_exp;
  assign bus.out_sticky = s2_sticky;
  assign bus.out_ovf    = s2_ovf;
  assign bus.out_unf    = s2_unf;
  assign bus.out_zero   = s2_zero;

endmodule
